// File: rtl/mmc_spi_pkg.sv
// Shared types and constants for the SPI-mode MMC/SD initiator.
// Holds the FSM encoding, the CRC7 polynomial and default dividers.
package mmc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam int unsigned SLOW_DIV_DEF = 26;
    localparam int unsigned FAST_DIV_DEF = 0;

    localparam int CNT_W = 16;

endpackage

// File: rtl/mmc_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0) over the transmitted bit stream.
// A clear takes priority over a bit update in the same cycle.
module mmc_crc7
    import mmc_spi_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = crc_q[6] ^ din;
        crc_d = crc_q;
        if (clr) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mmc_spi_master.sv
// SPI mode 0 byte initiator for MMC/SD with slow init and fast data clocks.
// Define MMC_SPI_CRC7_EN to add the crc_clr/crc7 command CRC generator.
module mmc_spi_master
    import mmc_spi_pkg::*;
#(
    parameter int unsigned SLOW_DIV = SLOW_DIV_DEF,
    parameter int unsigned FAST_DIV = FAST_DIV_DEF
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       speed_fast,
    input  logic       cs_assert,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       mmc_sck,
    output logic       mmc_mosi,
    output logic       mmc_cs,
    input  logic       mmc_miso
`ifdef MMC_SPI_CRC7_EN
    ,
    input  logic       crc_clr,
    output logic [6:0] crc7
`endif
);

    localparam logic [CNT_W-1:0] SLOW_LD = CNT_W'(SLOW_DIV);
    localparam logic [CNT_W-1:0] FAST_LD = CNT_W'(FAST_DIV);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             cs_q, cs_d;
    logic             rxv_q, rxv_d;
    logic             accept;
    logic             cnt_zero;

    // Ready drops for the rx_valid cycle so back-to-back bytes get a wider gap.
    assign tx_ready = (state_q == ST_IDLE) & ~rxv_q;
    assign busy     = (state_q != ST_IDLE);
    assign accept   = tx_valid & tx_ready;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOW;
            ST_LOW:  if (cnt_zero) state_d = ST_HIGH;
            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d = (bit_q == 3'd0) ? ST_DONE : ST_LOW;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_sr_d = tx_sr_q;
        rx_sr_d = rx_sr_q;
        rxd_d   = rxd_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        rxv_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cs_d   = ~cs_assert;
                mosi_d = 1'b1;
                if (accept) begin
                    tx_sr_d = tx_data[6:0];
                    mosi_d  = tx_data[7];
                    bit_d   = 3'd7;
                    div_d   = speed_fast ? FAST_LD : SLOW_LD;
                    cnt_d   = speed_fast ? FAST_LD : SLOW_LD;
                end
            end
            ST_LOW: begin
                if (cnt_zero) begin
                    sck_d   = 1'b1;
                    rx_sr_d = {rx_sr_q[6:0], mmc_miso};
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    sck_d = 1'b0;
                    if (bit_q != 3'd0) begin
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[5:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                        cnt_d   = div_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                rxv_d  = 1'b1;
                rxd_d  = rx_sr_q;
                mosi_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= 3'd0;
            tx_sr_q <= 7'h00;
            rx_sr_q <= 8'h00;
            rxd_q   <= 8'h00;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            cs_q    <= 1'b1;
            rxv_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_sr_q <= tx_sr_d;
            rx_sr_q <= rx_sr_d;
            rxd_q   <= rxd_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            rxv_q   <= rxv_d;
        end
    end

    assign mmc_sck  = sck_q;
    assign mmc_mosi = mosi_q;
    assign mmc_cs   = cs_q;
    assign rx_valid = rxv_q;
    assign rx_data  = rxd_q;

`ifdef MMC_SPI_CRC7_EN
    logic crc_en;
    // CRC sees the bit on MOSI at the rising edge, the same moment MISO is sampled.
    assign crc_en = (state_q == ST_LOW) & cnt_zero;

    mmc_crc7 u_crc7 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr     (crc_clr),
        .en      (crc_en),
        .din     (mosi_q),
        .crc     (crc7)
    );
`endif

endmodule

// File: tb/tb_mmc_spi_master.sv
// Self-checking bench for mmc_spi_master: vector table plus corner sequences.
// A scoreboard queue holds expected rx bytes; a monitor pops them on rx_valid.
module tb_mmc_spi_master;

    localparam int H_SLOW = 27;
    localparam int H_FAST = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       speed_fast = 1'b0;
    logic       cs_assert = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'hFF;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       mmc_sck;
    logic       mmc_mosi;
    logic       mmc_cs;
    logic       mmc_miso;
    logic       loop_en = 1'b0;
    logic       miso_fix = 1'b1;
`ifdef MMC_SPI_CRC7_EN
    logic       crc_clr = 1'b0;
    logic [6:0] crc7;
`endif

    always #5 clk = ~clk;

    assign mmc_miso = loop_en ? mmc_mosi : miso_fix;

    mmc_spi_master #(
        .SLOW_DIV (26),
        .FAST_DIV (0)
    ) dut (
        .clk_sys    (clk),
        .reset_n    (reset_n),
        .speed_fast (speed_fast),
        .cs_assert  (cs_assert),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .busy       (busy),
        .mmc_sck    (mmc_sck),
        .mmc_mosi   (mmc_mosi),
        .mmc_cs     (mmc_cs),
        .mmc_miso   (mmc_miso)
`ifdef MMC_SPI_CRC7_EN
        ,
        .crc_clr    (crc_clr),
        .crc7       (crc7)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out", nm);
    endtask

    logic [7:0] exp_q[$];
    int         rise_q[$];
    int         fall_q[$];
    int         rx_cnt = 0;
    logic       sck_prev = 1'b0;

    always @(negedge clk) begin
        if (mmc_sck === 1'b1 && sck_prev === 1'b0) rise_q.push_back(cyc);
        if (mmc_sck === 1'b0 && sck_prev === 1'b1) fall_q.push_back(cyc);
        sck_prev = mmc_sck;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got 0x%0h required none", rx_data);
            end else begin
                chk("rx_data", rx_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        int k;
        @(posedge clk);
        #1;
        tx_data  = b;
        tx_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) timeout("send");
        acc = cyc;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || tx_ready !== 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout("wait_done");
        tick(1);
    endtask

    task automatic wait_rxv(input int budget, output int at);
        int k;
        k = 0;
        @(negedge clk);
        while (rx_valid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) timeout("wait_rxv");
        at = cyc;
    endtask

    task automatic wait_rises(input int n);
        int k;
        k = 0;
        while (rise_q.size() < n && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 2000) timeout("wait_rises");
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       fast;
        logic       loop;
        logic       miso;
        logic [7:0] rx;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc, acc2, at, bad, n0;
        logic [7:0] cmd[10];

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'hFF};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3};

        // reset values and chip select latency
        tick(3);
        reset_n = 1'b1;
        tick(2);
        @(negedge clk);
        chk("rst_cs", mmc_cs, 1);
        chk("rst_sck", mmc_sck, 0);
        chk("rst_mosi", mmc_mosi, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxd", rx_data, 8'h00);
`ifdef MMC_SPI_CRC7_EN
        chk("rst_crc", crc7, 0);
`endif
        @(posedge clk);
        #1;
        cs_assert = 1'b1;
        @(negedge clk);
        chk("cs_before_edge", mmc_cs, 1);
        @(negedge clk);
        chk("cs_one_cycle", mmc_cs, 0);

        // vector table
        for (int i = 0; i < 6; i++) begin
            speed_fast = vecs[i].fast;
            loop_en    = vecs[i].loop;
            miso_fix   = vecs[i].miso;
            rise_q.delete();
            fall_q.delete();
            exp_q.push_back(vecs[i].rx);
            send(vecs[i].tx, acc);
            wait_done(2000);
            chk($sformatf("vec%0d_rises", i), rise_q.size(), 8);
        end

        // slow loopback timing
        speed_fast = 1'b0;
        loop_en    = 1'b1;
        rise_q.delete();
        fall_q.delete();
        exp_q.push_back(8'hA5);
        send(8'hA5, acc);
        wait_rxv(2000, at);
        chk("slow_rxv_cycle", at - acc, 2 + 16 * H_SLOW);
        chk("slow_ready_low", tx_ready, 0);
        @(negedge clk);
        chk("slow_ready_cycle", cyc - acc, 3 + 16 * H_SLOW);
        chk("slow_ready_high", tx_ready, 1);
        tick(1);
        chk("slow_rises", rise_q.size(), 8);
        chk("slow_falls", fall_q.size(), 8);
        if (rise_q.size() == 8 && fall_q.size() == 8) begin
            chk("slow_first_rise", rise_q[0] - acc, 1 + H_SLOW);
            chk("slow_last_fall", fall_q[7] - acc, 1 + 16 * H_SLOW);
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                if (fall_q[i] - rise_q[i] != H_SLOW) bad++;
                if (i > 0 && rise_q[i] - fall_q[i-1] != H_SLOW) bad++;
            end
            chk("slow_half_periods", bad, 0);
        end

        // fast burst with tx_valid held
        speed_fast = 1'b1;
        loop_en    = 1'b0;
        miso_fix   = 1'b0;
        rise_q.delete();
        fall_q.delete();
        n0 = rx_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        @(posedge clk);
        #1;
        tx_data = 8'h00;
        bad = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        if (bad >= 200) timeout("burst_second");
        acc2 = cyc;
        @(posedge clk);
        #1;
        tx_data = 8'h5A;
        tick(5);
        chk("burst_busy", busy, 1);
        tx_valid = 1'b0;
        tick(40);
        chk("burst_spacing", acc2 - acc, 3 + 16 * H_FAST);
        chk("burst_rx_count", rx_cnt - n0, 2);
        chk("burst_rises", rise_q.size(), 16);
        chk("burst_falls", fall_q.size(), 16);
        chk("burst_sb_empty", exp_q.size(), 0);
        if (rise_q.size() >= 9 && fall_q.size() >= 8) begin
            chk("burst_gap", (rise_q[8] - fall_q[7]) >= H_FAST + 2, 1);
        end

        // cs_assert / speed_fast changes mid-byte
        speed_fast = 1'b0;
        loop_en    = 1'b1;
        cs_assert  = 1'b1;
        tick(2);
        rise_q.delete();
        fall_q.delete();
        exp_q.push_back(8'h3C);
        send(8'h3C, acc);
        wait_rises(3);
        cs_assert  = 1'b0;
        speed_fast = 1'b1;
        bad = 0;
        n0 = 0;
        @(negedge clk);
        while (rx_valid !== 1'b1 && n0 < 2000) begin
            if (mmc_cs !== 1'b0) bad++;
            @(negedge clk);
            n0++;
        end
        if (n0 >= 2000) timeout("mid_rxv");
        chk("mid_cs_held", bad, 0);
        chk("mid_rxv_cycle", cyc - acc, 2 + 16 * H_SLOW);
        chk("mid_cs_at_rxv", mmc_cs, 0);
        tick(3);
        chk("mid_cs_after", mmc_cs, 1);

        // reset in the middle of a byte
        cs_assert  = 1'b1;
        speed_fast = 1'b0;
        tick(2);
        rise_q.delete();
        n0 = rx_cnt;
        send(8'h81, acc);
        wait_rises(4);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_sck", mmc_sck, 0);
        chk("mr_mosi", mmc_mosi, 1);
        chk("mr_cs", mmc_cs, 1);
        chk("mr_ready", tx_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_rxd", rx_data, 8'h00);
        tick(3);
        reset_n = 1'b1;
        tick(600);
        chk("mr_no_rxv", rx_cnt - n0, 0);
        chk("mr_idle", busy, 0);

`ifdef MMC_SPI_CRC7_EN
        cmd[0] = 8'h40; cmd[1] = 8'h00; cmd[2] = 8'h00;
        cmd[3] = 8'h00; cmd[4] = 8'h00;
        cmd[5] = 8'h48; cmd[6] = 8'h00; cmd[7] = 8'h00;
        cmd[8] = 8'h01; cmd[9] = 8'hAA;
        speed_fast = 1'b1;
        loop_en    = 1'b0;
        miso_fix   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            crc_clr = 1'b1;
            tick(1);
            crc_clr = 1'b0;
            chk($sformatf("crc%0d_clear", c), crc7, 0);
            for (int j = 0; j < 5; j++) begin
                exp_q.push_back(8'hFF);
                send(cmd[c * 5 + j], acc);
                wait_done(200);
            end
            chk($sformatf("crc%0d_value", c), crc7, c == 0 ? 7'h4A : 7'h43);
        end
`else
        cmd[0] = 8'h00;
        if (cmd[0] != 8'h00) $display("unused");
`endif

        chk("sb_final_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
